// File: rtl/mem_arbiter.sv
// Round-robin arbiter placing NUM_REQ requesters in front of one single-port synchronous memory.
// Optional WAIT timeout with error response is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int IDX_WIDTH  = $clog2(NUM_REQ),
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr_rd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [WIDTH-1:0]              resp_rdata,
   output logic                          resp_err,
   output logic                          busy,
   output logic                          mem_valid,
   output logic                          mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [WIDTH-1:0]              mem_wdata,
   input  logic [WIDTH-1:0]              mem_rdata,
   input  logic                          mem_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   state_t                state, state_nxt;
   logic [IDX_WIDTH-1:0]  ptr, ptr_nxt;
   logic [IDX_WIDTH-1:0]  winner, winner_nxt;
   logic [IDX_WIDTH-1:0]  pick;
   logic                  found;
   logic [NUM_REQ-1:0]    req_ready_nxt, resp_valid_nxt;
   logic [WIDTH-1:0]      resp_rdata_nxt, mem_wdata_nxt;
   logic                  busy_nxt, mem_valid_nxt, mem_wr_rd_nxt;
   logic [ADDR_WIDTH-1:0] mem_addr_nxt;
   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 resp_err_nxt;
`endif

   if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
      $error("mem_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
   end

   // Rotating search: the last winner has lowest priority on the next round.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[IDX_WIDTH'((int'(ptr) + k) % NUM_REQ)]) begin
            found = 1'b1;
            pick  = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      ptr_nxt        = ptr;
      winner_nxt     = winner;
      req_ready_nxt  = '0;
      resp_valid_nxt = '0;
      resp_rdata_nxt = resp_rdata;
      busy_nxt       = busy;
      mem_valid_nxt  = 1'b0;
      mem_wr_rd_nxt  = mem_wr_rd;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_nxt        = cnt;
      resp_err_nxt   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt     = ISSUE;
               winner_nxt    = pick;
               ptr_nxt       = pick;
               req_ready_nxt = ONE_HOT0 << pick;
               busy_nxt      = 1'b1;
               mem_valid_nxt = 1'b1;
               mem_wr_rd_nxt = req_wr_rd[pick];
               mem_addr_nxt  = addr_arr[pick];
               mem_wdata_nxt = wdata_arr[pick];
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_nxt   = '0;
`endif
         end
         WAIT: begin
            if (mem_ready) begin
               state_nxt      = IDLE;
               busy_nxt       = 1'b0;
               resp_valid_nxt = ONE_HOT0 << winner;
               if (!mem_wr_rd) begin
                  resp_rdata_nxt = mem_rdata;
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            // A ready on the final allowed cycle still completes normally.
            else if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
               state_nxt      = IDLE;
               busy_nxt       = 1'b0;
               resp_valid_nxt = ONE_HOT0 << winner;
               resp_err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= IDX_WIDTH'(NUM_REQ - 1);
         winner     <= '0;
         req_ready  <= '0;
         resp_valid <= '0;
         resp_rdata <= '0;
         busy       <= 1'b0;
         mem_valid  <= 1'b0;
         mem_wr_rd  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt        <= '0;
         resp_err   <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         winner     <= winner_nxt;
         req_ready  <= req_ready_nxt;
         resp_valid <= resp_valid_nxt;
         resp_rdata <= resp_rdata_nxt;
         busy       <= busy_nxt;
         mem_valid  <= mem_valid_nxt;
         mem_wr_rd  <= mem_wr_rd_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
         cnt        <= cnt_nxt;
         resp_err   <= resp_err_nxt;
`endif
      end
   end

`ifndef MEM_ARB_TIMEOUT_EN
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table plus hand-written
// sequences for simultaneous requests, rotation, mid-transaction reset and memory stalls.
module tb_mem_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 4;
   localparam int W       = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NUM_REQ-1:0] req_valid = '0;
   logic [NUM_REQ-1:0] req_wr_rd = '0;
   logic [NUM_REQ*AW-1:0] req_addr = '0;
   logic [NUM_REQ*W-1:0]  req_wdata = '0;
   logic [NUM_REQ-1:0] req_ready, resp_valid;
   logic [W-1:0]       resp_rdata;
   logic               resp_err, busy, mem_valid, mem_wr_rd;
   logic [AW-1:0]      mem_addr;
   logic [W-1:0]       mem_wdata;
   logic [W-1:0]       mem_rdata = '0;
   logic               mem_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] mem_arr [16];
   logic [W-1:0] mem_rd_q = '0;
   bit           mem_pend = 1'b0;
   bit           stall    = 1'b0;

   mem_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DEPTH   (16),
      .WIDTH   (W),
      .TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_wr_rd  (req_wr_rd),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .mem_valid  (mem_valid),
      .mem_wr_rd  (mem_wr_rd),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: one-cycle registered response, held off while stall is set.
   always @(posedge clk) begin
      if (mem_valid) begin
         if (mem_wr_rd) mem_arr[mem_addr] = mem_wdata;
         else           mem_rd_q = mem_arr[mem_addr];
         mem_pend = 1'b1;
      end
      if (mem_pend && !stall) begin
         mem_ready <= 1'b1;
         mem_rdata <= mem_rd_q;
         mem_pend = 1'b0;
      end else begin
         mem_ready <= 1'b0;
      end
   end

   typedef struct {
      int           r;
      logic         wr;
      logic [AW-1:0] addr;
      logic [W-1:0] wdata;
      logic [W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int r, input logic wr, input logic [AW-1:0] addr,
                                input logic [W-1:0] wdata);
      req_valid[r]             = 1'b1;
      req_wr_rd[r]             = wr;
      req_addr[r*AW +: AW]     = addr;
      req_wdata[r*W +: W]      = wdata;
   endtask

   // Called one negedge before the sampling edge E0; returns on the response cycle.
   task automatic serveOne(input int g, input logic [W-1:0] exp_rd, input bit drop);
      @(negedge clk);
      checkOutput("req_ready", 32'(req_ready), 32'(1 << g));
      checkOutput("issue mem_valid", 32'(mem_valid), 32'd1);
      checkOutput("issue busy", 32'(busy), 32'd1);
      if (drop) req_valid[g] = 1'b0;
      @(negedge clk);
      checkOutput("wait req_ready", 32'(req_ready), 32'd0);
      checkOutput("wait mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("wait resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      checkOutput("resp_valid", 32'(resp_valid), 32'(1 << g));
      checkOutput("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
      checkOutput("resp_err", 32'(resp_err), 32'd0);
      checkOutput("done busy", 32'(busy), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd0);
      checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, " resp_rdata"}, 32'(resp_rdata), 32'd0);
      checkOutput({tag, " resp_err"}, 32'(resp_err), 32'd0);
      checkOutput({tag, " busy"}, 32'(busy), 32'd0);
      checkOutput({tag, " mem_valid"}, 32'(mem_valid), 32'd0);
      checkOutput({tag, " mem_wr_rd"}, 32'(mem_wr_rd), 32'd0);
      checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem_arr[i] = '0;

      vecs[0] = '{2, 1'b1, 4'd3,  8'hA5, 8'h00};
      vecs[1] = '{2, 1'b0, 4'd3,  8'h00, 8'hA5};
      vecs[2] = '{1, 1'b1, 4'd0,  8'h5A, 8'hA5};
      vecs[3] = '{0, 1'b1, 4'd15, 8'h3C, 8'hA5};
      vecs[4] = '{3, 1'b0, 4'd0,  8'h00, 8'h5A};
      vecs[5] = '{0, 1'b0, 4'd15, 8'h00, 8'h3C};
      vecs[6] = '{1, 1'b0, 4'd3,  8'h00, 8'hA5};

      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;

      $display("[TB] single transactions from the vector table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].r, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         serveOne(vecs[i].r, vecs[i].exp_rdata, 1'b1);
      end
      @(negedge clk);
      checkOutput("resp_valid clears", 32'(resp_valid), 32'd0);

      $display("[TB] simultaneous requests after reset");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1'b0, 4'd3,  8'h00);
      applyStimulus(1, 1'b0, 4'd0,  8'h00);
      applyStimulus(2, 1'b0, 4'd15, 8'h00);
      applyStimulus(3, 1'b0, 4'd3,  8'h00);
      serveOne(0, 8'hA5, 1'b1);
      serveOne(1, 8'h5A, 1'b1);
      serveOne(2, 8'h3C, 1'b1);
      serveOne(3, 8'hA5, 1'b1);

      $display("[TB] rotation between requesters 1 and 3");
      applyStimulus(1, 1'b0, 4'd0,  8'h00);
      applyStimulus(3, 1'b0, 4'd15, 8'h00);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) serveOne(1, 8'h5A, 1'b0);
         else            serveOne(3, 8'h3C, 1'b0);
      end
      req_valid = '0;

      $display("[TB] reset during WAIT");
      @(negedge clk);
      applyStimulus(2, 1'b1, 4'd5, 8'h77);
      @(negedge clk);
      checkOutput("mid req_ready", 32'(req_ready), 32'h4);
      req_valid[2] = 1'b0;
      @(negedge clk);
      checkOutput("mid busy before reset", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      checkAllZero("mid reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("no resp after reset", 32'(resp_valid), 32'd0);
      end
      applyStimulus(0, 1'b0, 4'd5,  8'h00);
      applyStimulus(3, 1'b0, 4'd15, 8'h00);
      serveOne(0, 8'h77, 1'b1);
      serveOne(3, 8'h3C, 1'b1);

`ifdef MEM_ARB_TIMEOUT_EN
      $display("[TB] timeout with memory stalled");
      stall = 1'b1;
      applyStimulus(1, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checkOutput("to req_ready", 32'(req_ready), 32'h2);
      req_valid[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("to no resp", 32'(resp_valid), 32'd0);
      end
      @(negedge clk);
      checkOutput("to resp_valid", 32'(resp_valid), 32'h2);
      checkOutput("to resp_err", 32'(resp_err), 32'd1);
      checkOutput("to resp_rdata", 32'(resp_rdata), 32'h3C);
      checkOutput("to busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("to err clears", 32'(resp_err), 32'd0);
      stall = 1'b0;
`else
      $display("[TB] indefinite wait with memory stalled");
      stall = 1'b1;
      applyStimulus(1, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      checkOutput("stall req_ready", 32'(req_ready), 32'h2);
      req_valid[1] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput("stall no resp", 32'(resp_valid), 32'd0);
         checkOutput("stall busy", 32'(busy), 32'd1);
      end
      stall = 1'b0;
      @(negedge clk);
      checkOutput("stall release resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      checkOutput("stall resp_valid", 32'(resp_valid), 32'h2);
      checkOutput("stall resp_rdata", 32'(resp_rdata), 32'hA5);
      checkOutput("stall resp_err", 32'(resp_err), 32'd0);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-port synchronous memory (valid/ready, wr_rd, registered rdata) between NUM_REQ requesters. It sits directly in front of the memory instance. It accepts one request at a time, sequences the memory handshake and returns a one-cycle response pulse to the winner. Throughput is one transaction per 3 cycles.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥2.
- DEPTH, 16: memory depth in words.
- WIDTH, 8: data width.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- IDX_WIDTH, $clog2(NUM_REQ): grant index width.
- TIMEOUT, 15: WAIT cycles before an error response; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held high until req_ready.
- req_wr_rd  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  packed, same scheme.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_rdata  out  WIDTH  read data; shared bus, valid with resp_valid on reads.
- resp_err  out  1  high with resp_valid on a timeout.
- busy  out  1  high in ISSUE and WAIT.
- mem_valid  out  1  to memory valid.
- mem_wr_rd  out  1  to memory wr_rd.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wdata  out  WIDTH  to memory wdata.
- mem_rdata  in  WIDTH  from memory rdata.
- mem_ready  in  1  from memory ready.

## Operation
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE, no req_valid bit set: stay in IDLE.
- IDLE, any req_valid bit set:
  - Select the winner by searching from ptr+1 upward and wrapping modulo NUM_REQ.
  - Latch the winner index plus its wr_rd, addr and wdata into the mem_* registers.
  - Set ptr to the winner index.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_valid=1.
  - req_ready[winner]=1.
  - Go to WAIT.
- WAIT:
  - mem_valid=0.
  - When mem_ready=1: capture mem_rdata into resp_rdata (reads only; writes leave resp_rdata unchanged), pulse resp_valid[winner] in the next cycle, and return to IDLE.
- Requests arriving while busy stay pending. Only the IDLE state evaluates requests.
- Simultaneous requests: exactly one winner. The other requesters keep req_valid high and are served in later rounds, in rotation order.
- Writes and reads are treated identically. resp_err=0 on every normal completion.

## Timing
Reset values (asynchronous):
- state=IDLE, ptr=NUM_REQ-1 (requester 0 wins first).
- All of req_ready, resp_valid, resp_rdata, resp_err, busy, mem_valid, mem_wr_rd, mem_addr and mem_wdata are 0.

Cycle sequence, with request sampled at edge E0:
- Cycle after E0: ISSUE; mem_valid=1, req_ready pulse.
- Cycle after E1: WAIT; mem_ready=1 from the memory.
- Cycle after E2: IDLE; resp_valid pulse; a new arbitration can be sampled at E3.
- Request-to-response latency is 3 cycles. Back-to-back requests are served every 3 cycles.

Other timing rules:
- Requesters deassert req_valid on the edge following req_ready. Their request was already latched at E0.
- Reset mid-transaction drops the in-flight operation and issues no response pulse. Pending requesters must re-arbitrate after reset.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments on each WAIT cycle with mem_ready=0.
  - After TIMEOUT such consecutive cycles, pulse resp_valid[winner] with resp_err=1, leave resp_rdata unchanged, and return to IDLE.
  - A mem_ready arriving on the same cycle as the timeout wins: normal response.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter exists; WAIT waits indefinitely for mem_ready.
  - resp_err is tied to 0.

## Test plan
- Single write, then read: requester 2 writes 0xA5 to addr 3, then reads addr 3.
  - req_ready[2] pulses 1 cycle after request; resp_valid[2] pulses 3 cycles after request.
  - Read returns resp_rdata=0xA5, resp_err=0.
- Reset priority: all four requesters assert req_valid in the same cycle immediately after reset.
  - Grant order is 0,1,2,3, with responses 3 cycles apart.
- Rotation fairness: requesters 1 and 3 hold req_valid continuously for 6 transactions.
  - Grants alternate 1,3,1,3,1,3; no starvation.
- Write completion: requester 0 writes 0x3C to addr 15 (wrap-top address).
  - resp_valid[0] pulses; resp_rdata is unchanged from the prior read value.
- Reset mid-operation: assert rst during WAIT.
  - All outputs go to 0 immediately; no resp_valid pulse.
  - The next request from requester 0 is granted first.
- Timeout, with MEM_ARB_TIMEOUT_EN and TIMEOUT=4: tie mem_ready to 0.
  - resp_valid[winner]=1 and resp_err=1 after 4 WAIT cycles; FSM returns to IDLE.
